// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared parity constants, FSM state types and parity helper for the parametrised UART
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    // Words narrower than 8 bits are zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        case (mode)
            PARITY_ODD:  return ~^data;
            PARITY_EVEN: return ^data;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - rx synchroniser and single-word receive FSM with parity/framing checks
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] read_data,
    output logic                 read_vld,
    output logic                 parity_err,
    output logic                 frame_err
);

    localparam int TW  = $clog2(CLKS_PER_BIT);
    localparam int BCW = $clog2(DATA_BITS);
    localparam logic [TW-1:0]  T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0]  T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BCW-1:0] B_LAST = BCW'(DATA_BITS - 1);

    logic                 rx_meta;
    logic                 rx_sync;
    logic                 rx_prev;
    rx_state_t            state;
    logic [TW-1:0]        timer;
    logic [BCW-1:0]       bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 sample;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // The start bit is confirmed half a bit after the falling edge; later samples land mid-bit.
    assign sample = (timer == ((state == RX_START) ? T_HALF : T_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RX_IDLE;
            timer      <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            read_data  <= '0;
            read_vld   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            read_vld   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        state <= RX_START;
                        timer <= '0;
                    end
                end
                RX_BREAK: begin
                    if (rx_sync) state <= RX_IDLE;
                end
                default: begin
                    if (!sample) begin
                        timer <= timer + 1'b1;
                    end else begin
                        timer <= '0;
                        case (state)
                            RX_START: begin
                                state   <= rx_sync ? RX_IDLE : RX_DATA;
                                bit_cnt <= '0;
                            end
                            RX_DATA: begin
                                shreg <= {rx_sync, shreg[DATA_BITS-1:1]};
                                if (bit_cnt == B_LAST)
                                    state <= (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
                                else
                                    bit_cnt <= bit_cnt + 1'b1;
                            end
                            RX_PARITY: begin
                                par_bit <= rx_sync;
                                state   <= RX_STOP;
                            end
                            RX_STOP: begin
                                read_data  <= shreg;
                                read_vld   <= 1'b1;
                                parity_err <= (PARITY != PARITY_NONE) &&
                                              (par_bit != parity_bit(8'(shreg), PARITY));
                                frame_err  <= !rx_sync;
                                state      <= rx_sync ? RX_IDLE : RX_BREAK;
                            end
                            default: state <= RX_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_param.sv
// rtl/uart_param.sv - parametrised full-duplex UART: multi-word TX command path plus receive frame decoder
module uart_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int NWORDS       = 2,
    parameter int PARITY       = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_BITS*NWORDS-1:0] cmd_in,
    input  logic                        cmd_vld,
    output logic                        cmd_rdy,
    output logic                        tx,
    input  logic                        rx,
    output logic [DATA_BITS-1:0]        read_data,
    output logic                        read_vld,
    output logic                        parity_err,
    output logic                        frame_err
);

    if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_clks
        $error("uart_param: CLKS_PER_BIT must be >= 4 and even");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
        $error("uart_param: DATA_BITS must be 5..8");
    end
    if (NWORDS < 1 || NWORDS > 4) begin : g_bad_nwords
        $error("uart_param: NWORDS must be 1..4");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_param: STOP_BITS must be 1 or 2");
    end

    localparam int TW  = $clog2(CLKS_PER_BIT);
    localparam int BCW = $clog2(DATA_BITS);
    localparam int WCW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [TW-1:0]  T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BCW-1:0] B_LAST = BCW'(DATA_BITS - 1);
    localparam logic [WCW-1:0] W_LAST = WCW'(NWORDS - 1);
    localparam logic           S_LAST = 1'(STOP_BITS - 1);

    tx_state_t                   tx_state;
    logic [DATA_BITS*NWORDS-1:0] payload;
    logic [TW-1:0]               timer;
    logic [BCW-1:0]              bit_cnt;
    logic [BCW-1:0]              next_bit;
    logic [WCW-1:0]              word_cnt;
    logic                        stop_cnt;
    logic [DATA_BITS-1:0]        cur_word;

    // Word 0 on the wire is the most significant word of the payload.
    always_comb begin
        cur_word = '0;
        for (int w = 0; w < NWORDS; w++) begin
            if (WCW'(w) == word_cnt)
                cur_word = payload[(NWORDS-1-w)*DATA_BITS +: DATA_BITS];
        end
    end

    assign next_bit = bit_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx       <= 1'b1;
            cmd_rdy  <= 1'b1;
            payload  <= '0;
            timer    <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            stop_cnt <= 1'b0;
        end else if (tx_state == TX_IDLE) begin
            if (cmd_vld && cmd_rdy) begin
                payload  <= cmd_in;
                cmd_rdy  <= 1'b0;
                tx       <= 1'b0;
                timer    <= '0;
                word_cnt <= '0;
                tx_state <= TX_START;
            end
        end else if (timer != T_LAST) begin
            timer <= timer + 1'b1;
        end else begin
            timer <= '0;
            case (tx_state)
                TX_START: begin
                    tx_state <= TX_DATA;
                    bit_cnt  <= '0;
                    tx       <= cur_word[0];
                end
                TX_DATA: begin
                    if (bit_cnt != B_LAST) begin
                        bit_cnt <= next_bit;
                        tx      <= cur_word[next_bit];
                    end else if (PARITY != PARITY_NONE) begin
                        tx_state <= TX_PARITY;
                        tx       <= parity_bit(8'(cur_word), PARITY);
                    end else begin
                        tx_state <= TX_STOP;
                        tx       <= 1'b1;
                        stop_cnt <= 1'b0;
                    end
                end
                TX_PARITY: begin
                    tx_state <= TX_STOP;
                    tx       <= 1'b1;
                    stop_cnt <= 1'b0;
                end
                TX_STOP: begin
                    if (stop_cnt != S_LAST) begin
                        stop_cnt <= 1'b1;
                    end else if (word_cnt == W_LAST) begin
                        tx_state <= TX_IDLE;
                        cmd_rdy  <= 1'b1;
                        tx       <= 1'b1;
                    end else begin
                        word_cnt <= word_cnt + 1'b1;
                        tx_state <= TX_START;
                        tx       <= 1'b0;
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                    cmd_rdy  <= 1'b1;
                    tx       <= 1'b1;
                end
            endcase
        end
    end

    uart_rx_frame #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .DATA_BITS    (DATA_BITS),
        .PARITY       (PARITY)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .read_data  (read_data),
        .read_vld   (read_vld),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

endmodule

// File: tb/tb_uart_param.sv
// tb/tb_uart_param.sv - scoreboard bench for uart_param: tx frames, loopback, rx errors, false start, reset abort
module tb_uart_param;

    localparam int CPB = 4;
    localparam int F   = 11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cmd_in = '0;
    logic        cmd_vld = 1'b0;
    logic        cmd_rdy;
    logic        tx;
    logic        rx_drv = 1'b1;
    logic        loop_en = 1'b0;
    logic        rx_line;
    logic [7:0]  read_data;
    logic        read_vld;
    logic        parity_err;
    logic        frame_err;

    int vectors = 0;
    int miscompares = 0;

    logic [F-1:0] tx_q[$];
    logic [9:0]   rx_q[$];

    assign rx_line = loop_en ? tx : rx_drv;

    always #5 clk = ~clk;

    uart_param #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .NWORDS       (2),
        .PARITY       (1),
        .STOP_BITS    (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_in     (cmd_in),
        .cmd_vld    (cmd_vld),
        .cmd_rdy    (cmd_rdy),
        .tx         (tx),
        .rx         (rx_line),
        .read_data  (read_data),
        .read_vld   (read_vld),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Expected serial frame, time order from bit 0: start, data LSB first, parity, stop.
    task automatic push_tx(input logic [7:0] d, input logic par);
        tx_q.push_back({1'b1, par, d, 1'b0});
    endtask

    task automatic push_rx(input logic [7:0] d, input logic perr, input logic ferr);
        rx_q.push_back({d, perr, ferr});
    endtask

    task automatic wait_rdy(input int budget);
        int n = 0;
        while (cmd_rdy !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (cmd_rdy !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_rdy: cmd_rdy still %b after %0d cycles", cmd_rdy, budget);
        end
    endtask

    task automatic count_low(output int n);
        n = 0;
        while (cmd_rdy === 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic send_pulse(input logic [15:0] d);
        wait_rdy(400);
        @(negedge clk);
        cmd_in  = d;
        cmd_vld = 1'b1;
        @(negedge clk);
        cmd_vld = 1'b0;
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic par, input logic stp);
        logic [10:0] bits;
        bits = {stp, par, d, 1'b0};
        for (int b = 0; b < 11; b++) begin
            rx_drv = bits[b];
            repeat (CPB) @(negedge clk);
        end
    endtask

    initial begin : tx_mon
        logic [F-1:0] got;
        logic [F-1:0] exp;
        bit aborted;
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                aborted = 1'b0;
                for (int b = 0; b < F; b++) begin
                    repeat ((b == 0) ? CPB / 2 : CPB) @(negedge clk);
                    if (!rst_n) aborted = 1'b1;
                    got[b] = tx;
                end
                if (!aborted) begin
                    if (tx_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL tx_frame: unexpected frame %b", got);
                    end else begin
                        exp = tx_q.pop_front();
                        check("tx_frame", 32'(got), 32'(exp));
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && read_vld === 1'b1) begin
            if (rx_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rx_word: unexpected read_vld data %h perr %b ferr %b",
                         read_data, parity_err, frame_err);
            end else begin
                check("rx_word", 32'({read_data, parity_err, frame_err}), 32'(rx_q.pop_front()));
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : stim
        int n;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_cmd_rdy", 32'(cmd_rdy), 32'd1);
        check("rst_read_data", 32'(read_data), 32'd0);
        check("rst_read_vld", 32'(read_vld), 32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Basic TX: A5 then 5A, both with odd parity bit 1.
        push_tx(8'hA5, 1'b1);
        push_tx(8'h5A, 1'b1);
        send_pulse(16'hA55A);
        count_low(n);
        check("basic_rdy_low", 32'(n), 32'd88);
        repeat (5) @(negedge clk);

        // Back-to-back: second command held on cmd_vld is taken the cycle cmd_rdy rises.
        wait_rdy(400);
        @(negedge clk);
        cmd_in  = 16'h0001;
        cmd_vld = 1'b1;
        push_tx(8'h00, 1'b1);
        push_tx(8'h01, 1'b0);
        n = 0;
        while (cmd_rdy === 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        cmd_in = 16'hFF00;
        push_tx(8'hFF, 1'b1);
        push_tx(8'h00, 1'b1);
        count_low(n);
        check("b2b_rdy_low", 32'(n), 32'd88);
        n = 0;
        while (cmd_rdy === 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("b2b_rdy_high_cycles", 32'(n), 32'd1);
        cmd_vld = 1'b0;
        count_low(n);
        check("b2b_second_rdy_low", 32'(n), 32'd88);
        repeat (5) @(negedge clk);

        // Loopback: both words come back on the receiver without errors.
        loop_en = 1'b1;
        push_tx(8'h3C, 1'b1);
        push_tx(8'hC3, 1'b1);
        push_rx(8'h3C, 1'b0, 1'b0);
        push_rx(8'hC3, 1'b0, 1'b0);
        send_pulse(16'h3CC3);
        wait_rdy(400);
        repeat (20) @(negedge clk);
        loop_en = 1'b0;
        repeat (5) @(negedge clk);

        // RX parity error, then framing error followed by a long break.
        push_rx(8'h3C, 1'b1, 1'b0);
        rx_frame(8'h3C, 1'b0, 1'b1);
        rx_drv = 1'b1;
        repeat (10) @(negedge clk);
        push_rx(8'h3C, 1'b0, 1'b1);
        rx_frame(8'h3C, 1'b1, 1'b0);
        repeat (100) @(negedge clk);
        rx_drv = 1'b1;
        repeat (10) @(negedge clk);

        // False start, then a good frame proves the receiver returned to idle.
        rx_drv = 1'b0;
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (30) @(negedge clk);
        push_rx(8'h96, 1'b0, 1'b0);
        rx_frame(8'h96, 1'b1, 1'b1);
        rx_drv = 1'b1;
        repeat (10) @(negedge clk);

        // Reset during data bit 3 of the first word.
        send_pulse(16'h1234);
        repeat (17) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_tx", 32'(tx), 32'd1);
        check("abort_cmd_rdy", 32'(cmd_rdy), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        push_tx(8'h80, 1'b0);
        push_tx(8'h01, 1'b0);
        send_pulse(16'h8001);
        count_low(n);
        check("post_reset_rdy_low", 32'(n), 32'd88);
        repeat (20) @(negedge clk);

        check("tx_queue_drained", 32'(tx_q.size()), 32'd0);
        check("rx_queue_drained", 32'(rx_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_param.md
Name: uart_param

Overview:
Parametrised full-duplex UART with a valid/ready command port and a received-word output port.
- TX: accepts a command of NWORDS data words and serialises them back-to-back, each as start/data/parity/stop.
- RX: deserialises single words with mid-bit sampling and flags parity and framing errors.
- Sits between the command/register logic and the chip serial pins. Generalises the fixed 2×8-bit odd-parity UART with configurable word count, data width, parity mode, stop bits and baud divisor.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit; must be ≥4 and even.
- DATA_BITS, 8: data bits per word, legal range 5–8.
- NWORDS, 2: words per TX command, legal range 1–4.
- PARITY, 1: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_in  in  DATA_BITS*NWORDS  TX payload; word NWORDS-1 (MS word) is sent first.
- cmd_vld  in  1  payload valid.
- cmd_rdy  out  1  TX idle, able to accept.
- tx  out  1  serial out, idles high.
- rx  in  1  serial in, asynchronous.
- read_data  out  DATA_BITS  last received word.
- read_vld  out  1  one-cycle pulse when read_data updates.
- parity_err  out  1  one-cycle pulse with read_vld; parity mismatch.
- frame_err  out  1  one-cycle pulse with read_vld; stop bit sampled 0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. All flops reset asynchronously.
- Reset values: tx=1, cmd_rdy=1, read_data=0, read_vld=0, parity_err=0, frame_err=0. Both FSMs reset to IDLE.
- TX handshake:
  - Transfer occurs when cmd_vld && cmd_rdy at a rising edge. cmd_in is latched into a shift register; cmd_rdy=0 from the next cycle.
  - cmd_vld while cmd_rdy=0 is ignored; no queueing.
- TX FSM: IDLE → START → DATA → PARITY (skipped if PARITY=0) → STOP → next word START, or IDLE after the last word.
  - The start bit drives tx=0 from the cycle after acceptance.
  - Each bit is held exactly CLKS_PER_BIT cycles. Data is sent LSB first.
  - Parity bit: odd gives XNOR of the word's bits, even gives XOR.
  - Words follow with no idle gap.
- TX frame length: F = 1+DATA_BITS+(PARITY!=0)+STOP_BITS bits. cmd_rdy is low for exactly NWORDS*F*CLKS_PER_BIT cycles and returns to 1 in the cycle after the last stop bit completes. A new command may be accepted in that same cycle, giving back-to-back frames.
- RX synchroniser: 2-flop on rx. All RX logic uses the synchronised value.
- RX FSM: IDLE → START → DATA → PARITY (if enabled) → STOP → IDLE, or → BREAK.
  - IDLE: a sync-rx 1→0 transition starts the bit counter.
  - START: at CLKS_PER_BIT/2 rx is re-checked. If high, it is a false start: return to IDLE with no outputs.
  - Data, parity and stop bits are each sampled once, CLKS_PER_BIT after the previous sample (mid-bit).
  - Only the first stop bit is checked. A second stop bit is tolerated as idle.
  - The cycle after the stop sample: read_data is updated (even if errored), read_vld=1, and parity_err/frame_err are set as applicable, all for one cycle.
  - If frame_err: enter BREAK and wait for sync rx=1 before IDLE. A continuous low line produces exactly one frame_err.
- TX and RX are independent. Simultaneous activity and loopback (rx tied to tx) are legal.
- Reset mid-operation: immediate abort of both directions, outputs to reset values, partial RX word discarded.
- Counters: bit-timer width is $clog2(CLKS_PER_BIT). Bit and word counters are sized to their maxima with no wrap beyond the terminal value.
- Illegal parameters: reject at elaboration with $error.

Decomposition:
- Package uart_pkg:
  - PARITY_NONE/ODD/EVEN constants;
  - tx_state_t and rx_state_t enums;
  - function parity_bit(data, mode).
- One natural sub-module, uart_rx_frame: synchroniser plus RX FSM. uart_param instantiates it and holds the TX path and command handshake.

Test Plan:
All tests use CLKS_PER_BIT=4, DATA_BITS=8, NWORDS=2, PARITY=1, STOP_BITS=1, giving F=11 bits.
1. Basic TX: cmd_in=16'hA55A, pulse cmd_vld.
   - Required: tx sends 0, bits of A5 LSB-first (1,0,1,0,0,1,0,1), parity 1, stop 1, then the same frame shape for 5A with parity 1.
   - Required: cmd_rdy low for exactly 88 cycles.
2. Back-to-back: hold cmd_vld with 16'h0001 then 16'hFF00.
   - Required: second accepted on the cycle cmd_rdy rises; no idle-high gap on tx.
   - Required parity bits: 00→1, 01→0, FF→1, 00→1.
3. Loopback (rx=tx), send 16'h3CC3.
   - Required: read_vld pulses twice, read_data 3C then C3, parity_err=frame_err=0.
4. RX errors.
   - Drive frame 0x3C with parity bit 0: read_data=3C, read_vld=1, parity_err=1.
   - Next frame 0x3C, parity bit 1, stop 0: frame_err=1. Then hold rx low for 100 cycles: no further pulses.
5. False start: rx low for 1 cycle, then high. Required: no read_vld, RX back in IDLE.
6. Reset mid-TX: assert rst_n=0 during the DATA bit 3 of the first word. Required: tx=1 and cmd_rdy=1 immediately (asynchronously); after release a fresh command transmits correctly.
